// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default framing constants and parity helper.
// The parity bit is only present when the build defines UART_RX_PARITY_EN.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 16;
    localparam int unsigned DATA_BITS_DEF    = 8;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxParity,
        RxStop,
        RxWaitIdle
    } rx_state_e;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial input.
// Both flops reset to 1, the idle level of the line.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
        end
    end

    assign rx_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized input, mid-bit sampling, LSB-first shift register.
// Defining UART_RX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx_dataIn,
    output logic [DATA_BITS-1:0] Rx_data,
    output logic                 Rx_valid,
    output logic                 Parity_err,
    output logic                 Frame_err,
    output logic                 Rx_busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(DATA_BITS);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntMid = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IdxW-1:0] BitMax = IdxW'(DATA_BITS - 1);

    logic rx_sync;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx_i (Rx_dataIn),
        .rx_o (rx_sync)
    );

    rx_state_e            state_q;
    logic [CntW-1:0]      cnt_q;
    logic [IdxW-1:0]      bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic                 parity_q;
    logic                 parity_err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RxIdle;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state_q)
                RxIdle: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (!rx_sync) state_q <= RxStart;
                end
                RxStart: begin
                    // Mid-start sample: a high line here was only a glitch.
                    if (cnt_q == CntMid) begin
                        cnt_q   <= '0;
                        state_q <= rx_sync ? RxIdle : RxData;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                RxData: begin
                    if (cnt_q == CntMax) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync, shift_q[DATA_BITS-1:1]};
                        bit_q   <= bit_q + IdxW'(1);
                        if (bit_q == BitMax) begin
                            bit_q   <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q <= RxParity;
`else
                            state_q <= RxStop;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                RxParity: begin
                    if (cnt_q == CntMax) begin
                        cnt_q   <= '0;
`ifdef UART_RX_PARITY_EN
                        parity_q <= rx_sync;
`endif
                        state_q <= RxStop;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                RxStop: begin
                    if (cnt_q == CntMax) begin
                        cnt_q        <= '0;
                        rx_valid_q   <= 1'b1;
                        rx_data_q    <= shift_q;
                        frame_err_q  <= ~rx_sync;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= even_parity(8'(shift_q)) ^ parity_q;
`endif
                        state_q      <= rx_sync ? RxIdle : RxWaitIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                RxWaitIdle: begin
                    // Break condition: stay here until the line returns high.
                    cnt_q <= '0;
                    if (rx_sync) state_q <= RxIdle;
                end
                default: state_q <= RxIdle;
            endcase
        end
    end

    assign Rx_data   = rx_data_q;
    assign Rx_valid  = rx_valid_q;
    assign Frame_err = frame_err_q;
    assign Rx_busy   = (state_q != RxIdle);
`ifdef UART_RX_PARITY_EN
    assign Parity_err = parity_err_q;
`else
    assign Parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (CLKS_PER_BIT=16, DATA_BITS=8).
// Parity bits are driven and checked only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int unsigned Cpb = 16;

    logic       clk;
    logic       rst;
    logic       Rx_dataIn;
    logic [7:0] Rx_data;
    logic       Rx_valid;
    logic       Parity_err;
    logic       Frame_err;
    logic       Rx_busy;

    int n_checks;
    int n_errors;
    int valid_cnt;
    int busy_cycles;

    uart_rx #(
        .CLKS_PER_BIT (Cpb),
        .DATA_BITS    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Rx_dataIn  (Rx_dataIn),
        .Rx_data    (Rx_data),
        .Rx_valid   (Rx_valid),
        .Parity_err (Parity_err),
        .Frame_err  (Frame_err),
        .Rx_busy    (Rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every cycle Rx_valid is high, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (Rx_valid) valid_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        Rx_dataIn = b;
        repeat (Cpb) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par) begin end
`endif
        send_bit(stop);
    endtask

    int base;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        valid_cnt = 0;
        Rx_dataIn = 1'b1;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, Rx_valid}, 32'd0);
        check("rst_data", {24'd0, Rx_data}, 32'd0);
        check("rst_perr", {31'd0, Parity_err}, 32'd0);
        check("rst_ferr", {31'd0, Frame_err}, 32'd0);
        check("rst_busy", {31'd0, Rx_busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Clean frame
        base = valid_cnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        check("a5_count", valid_cnt - base, 32'd1);
        check("a5_data", {24'd0, Rx_data}, 32'hA5);
        check("a5_perr", {31'd0, Parity_err}, 32'd0);
        check("a5_ferr", {31'd0, Frame_err}, 32'd0);
        repeat (Cpb) @(negedge clk);
        check("a5_idle", {31'd0, Rx_busy}, 32'd0);

        // Wrong parity bit for 0x07 (three ones need parity 1)
        base = valid_cnt;
        send_frame(8'h07, 1'b0, 1'b1);
        check("p07_count", valid_cnt - base, 32'd1);
        check("p07_data", {24'd0, Rx_data}, 32'h07);
`ifdef UART_RX_PARITY_EN
        check("p07_perr", {31'd0, Parity_err}, 32'd1);
`else
        check("p07_perr", {31'd0, Parity_err}, 32'd0);
`endif
        check("p07_ferr", {31'd0, Frame_err}, 32'd0);
        repeat (Cpb) @(negedge clk);

        // Stop bit low, then a 40-bit break
        base = valid_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        check("brk_count", valid_cnt - base, 32'd1);
        check("brk_data", {24'd0, Rx_data}, 32'h3C);
        check("brk_ferr", {31'd0, Frame_err}, 32'd1);
        repeat (40 * Cpb) @(negedge clk);
        check("brk_hold_count", valid_cnt - base, 32'd1);
        check("brk_hold_busy", {31'd0, Rx_busy}, 32'd1);
        Rx_dataIn = 1'b1;
        repeat (Cpb) @(negedge clk);
        check("brk_release_busy", {31'd0, Rx_busy}, 32'd0);
        send_frame(8'h12, 1'b0, 1'b1);
        check("brk_next_count", valid_cnt - base, 32'd2);
        check("brk_next_data", {24'd0, Rx_data}, 32'h12);
        check("brk_next_ferr", {31'd0, Frame_err}, 32'd0);
        repeat (Cpb) @(negedge clk);

        // 4-cycle glitch on an idle line
        base        = valid_cnt;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            Rx_dataIn = (i < 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (Rx_busy) busy_cycles++;
        end
        check("glitch_count", valid_cnt - base, 32'd0);
        check("glitch_busy_seen", {31'd0, busy_cycles > 0}, 32'd1);
        check("glitch_busy_le10", {31'd0, busy_cycles <= 10}, 32'd1);
        check("glitch_idle", {31'd0, Rx_busy}, 32'd0);

        // Back-to-back frames, no idle gap
        base = valid_cnt;
        send_frame(8'h55, 1'b0, 1'b1);
        check("b2b_first_count", valid_cnt - base, 32'd1);
        check("b2b_first_data", {24'd0, Rx_data}, 32'h55);
        send_frame(8'hAA, 1'b0, 1'b1);
        check("b2b_second_count", valid_cnt - base, 32'd2);
        check("b2b_second_data", {24'd0, Rx_data}, 32'hAA);
        check("b2b_perr", {31'd0, Parity_err}, 32'd0);
        check("b2b_ferr", {31'd0, Frame_err}, 32'd0);
        repeat (Cpb) @(negedge clk);

        // Reset during data bit 4 of 0xFF
        base = valid_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (Cpb / 2) @(negedge clk);
        check("mid_busy", {31'd0, Rx_busy}, 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_data", {24'd0, Rx_data}, 32'd0);
        rst = 1'b0;
        repeat (12 * Cpb) @(negedge clk);
        check("mid_no_valid", valid_cnt - base, 32'd0);
        check("mid_idle", {31'd0, Rx_busy}, 32'd0);
        send_frame(8'h81, 1'b0, 1'b1);
        check("r81_count", valid_cnt - base, 32'd1);
        check("r81_data", {24'd0, Rx_data}, 32'h81);
        check("r81_perr", {31'd0, Parity_err}, 32'd0);
        check("r81_ferr", {31'd0, Frame_err}, 32'd0);
        repeat (4 * Cpb) @(negedge clk);
        check("final_count", valid_cnt - base, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, 16, clk cycles per serial bit period (min 4, even).
REQ-002 SHALL provide parameter DATA_BITS, 8, data bits per frame (5..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Rx_dataIn  input  1  serial line; idle high, asynchronous to clk.
REQ-006 SHALL have port Rx_data  output  DATA_BITS  last received data word.
REQ-007 SHALL have port Rx_valid  output  1  one-cycle pulse; frame complete.
REQ-008 SHALL have port Parity_err  output  1  parity error status, qualified by Rx_valid.
REQ-009 SHALL have port Frame_err  output  1  stop-bit error status, qualified by Rx_valid.
REQ-010 SHALL have port Rx_busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass Rx_dataIn through a 2-flop synchronizer before any use; all timing below is relative to the synchronized line.
REQ-012 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-013 SHALL leave IDLE for START on the first synchronized low; bit counter cleared.
REQ-014 In START, the FSM SHALL sample at count CLKS_PER_BIT/2-1: if low, go to DATA; if high, treat as glitch and return to IDLE with no output.
REQ-015 In DATA, the FSM SHALL sample each bit every CLKS_PER_BIT cycles after the start mid-sample, shift in LSB first, and leave after DATA_BITS samples.
REQ-016 PARITY SHALL sample one bit; the check is even parity: XOR of data bits and parity bit SHALL be 0, else Parity_err=1.
REQ-017 STOP SHALL sample one bit: high gives Frame_err=0 and a move to IDLE; low gives Frame_err=1 and a move to WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL hold until the synchronized line is high, then go to IDLE; a break (line held low) SHALL NOT produce further frames.
REQ-019 Rx_valid SHALL pulse for exactly one cycle, the cycle after the stop-bit sample, for every frame that passed the start check, including errored frames.
REQ-020 Rx_data, Parity_err and Frame_err SHALL update in the same cycle Rx_valid rises and hold until the next Rx_valid.
REQ-021 A new start bit SHALL be accepted in the cycle after Rx_valid, giving back-to-back frames with no idle gap.
REQ-022 The bit counter SHALL be sized $clog2(CLKS_PER_BIT) and SHALL wrap to 0 at CLKS_PER_BIT-1.

Reset
REQ-023 rst SHALL force IDLE, all counters 0, Rx_data=0, Rx_valid=0, Parity_err=0, Frame_err=0, Rx_busy=0, and synchronizer flops=1.
REQ-024 Reset mid-frame SHALL discard the partial frame with no Rx_valid pulse; the next start SHALL be detected normally after release.

Configuration
REQ-025 With macro UART_RX_PARITY_EN defined, the PARITY state and check SHALL exist as in REQ-016.
REQ-026 Without UART_RX_PARITY_EN, DATA SHALL go directly to STOP, Parity_err SHALL be tied 0, and the frame SHALL be one bit shorter.

Structure
REQ-027 Package uart_pkg SHALL hold the rx state enum, the default constants (CLKS_PER_BIT, DATA_BITS) and an even-parity function shared with the transmitter.
REQ-028 The synchronizer SHALL be the sub-module uart_rx_sync (2 flops, reset value 1); the FSM, counters and shift register SHALL stay in uart_rx.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, parity enabled unless noted)
REQ-029 Send 0xA5 with parity 0 and stop 1 -> one Rx_valid, Rx_data=0xA5, Parity_err=0, Frame_err=0.
REQ-030 Send 0x07 with parity 0 (wrong) -> Rx_valid, Rx_data=0x07, Parity_err=1, Frame_err=0.
REQ-031 Send 0x3C with stop bit 0, then hold the line low for 40 bit periods -> exactly one Rx_valid with Frame_err=1, then no further pulses until the line goes high and a new frame is sent.
REQ-032 Apply a 4-cycle low glitch on an idle line -> no Rx_valid; Rx_busy high for at most 10 cycles, then back to IDLE.
REQ-033 Send 0x55 then 0xAA back-to-back with zero idle gap -> two Rx_valid pulses, data 0x55 then 0xAA, no errors.
REQ-034 Assert rst during bit 4 of 0xFF, then release and send 0x81 -> no Rx_valid for 0xFF, then Rx_valid with Rx_data=0x81; rebuild without UART_RX_PARITY_EN and send 0x81 with no parity bit -> Rx_data=0x81, Parity_err=0.
